cr_ram1_engine_fifo: RTL and testbench

CR_RAM1_ENGINE_FIFO -- requirements
Module: cr_ram1_engine_fifo

---
 rtl/cr_ram1_engine_fifo.sv | 153 +++++++++++++++
 tb/tb_cr_ram1_engine_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cr_ram1_engine_fifo.sv
// ---------------------------------------------------------------------------
// cr_ram1_engine_fifo : RAM0 words -> input FIFO -> RAM1 read engine ->
// output FIFO -> AXI-Stream-style master.            Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cr_ram1_engine_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          overflow_q;
  logic          w_pop, w_push;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == C_FULL);
  assign overflow_o = overflow_q;
  assign rdata_o    = mem[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when paired with a pop; a pop on empty is ignored.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_push && !w_pop)      count_q <= count_q + 1'b1;
      else if (w_pop && !w_push) count_q <= count_q - 1'b1;
      if (push_i && !w_push) overflow_q <= 1'b1;
    end
  end
endmodule

module cr_ram1_engine_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ram0_data,
  input  logic              ram0_valid,
  input  logic              ram1_ready,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram1_read,
  input  logic [DATA_W-1:0] ram1_data,
  input  logic              ram1_valid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              in_full,
  output logic              in_empty,
  output logic              in_overflow,
  output logic              out_full,
  output logic              out_empty,
  output logic              out_overflow
);
  logic [DATA_W-1:0] w_in_head;
  logic [DATA_W-1:0] w_out_head;
  logic              w_eng_pop;
  logic              w_out_pop;
  logic [ADDR_W-1:0] ram1_addr_q, ram1_addr_d;
  logic              ram1_read_q, ram1_read_d;

  cr_ram1_engine_fifo_buf #(.DEPTH(IN_DEPTH), .W(DATA_W)) u_in_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (ram0_valid),
    .wdata_i    (ram0_data),
    .pop_i      (w_eng_pop),
    .rdata_o    (w_in_head),
    .full_o     (in_full),
    .empty_o    (in_empty),
    .overflow_o (in_overflow)
  );

  assign w_eng_pop = ~in_empty & ram1_ready;

  always_comb begin
    ram1_read_d = w_eng_pop;
    ram1_addr_d = ram1_addr_q;
    if (w_eng_pop) ram1_addr_d = w_in_head[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram1_read_q <= 1'b0;
      ram1_addr_q <= '0;
    end else begin
      ram1_read_q <= ram1_read_d;
      ram1_addr_q <= ram1_addr_d;
    end
  end

  assign ram1_read = ram1_read_q;
  assign ram1_addr = ram1_addr_q;

  // Only the low ADDR_W bits of a RAM0 word form the RAM1 address.
  generate
    if (ADDR_W < DATA_W) begin : g_head_hi
      logic unused_head_hi;
      assign unused_head_hi = ^w_in_head[DATA_W-1:ADDR_W];
    end
  endgenerate

  cr_ram1_engine_fifo_buf #(.DEPTH(OUT_DEPTH), .W(DATA_W)) u_out_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (ram1_valid),
    .wdata_i    (ram1_data),
    .pop_i      (w_out_pop),
    .rdata_o    (w_out_head),
    .full_o     (out_full),
    .empty_o    (out_empty),
    .overflow_o (out_overflow)
  );

  assign m_tvalid  = ~out_empty;
  assign w_out_pop = m_tvalid & m_tready;
  // Masked while empty so no stale word is ever presented.
  assign m_tdata   = out_empty ? '0 : w_out_head;
  assign m_tlast   = 1'b0;
endmodule

`default_nettype wire

// File: tb/tb_cr_ram1_engine_fifo.sv
// ---------------------------------------------------------------------------
// tb_cr_ram1_engine_fifo : directed table-driven bench for cr_ram1_engine_fifo.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cr_ram1_engine_fifo;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] ram0_data, ram1_data, m_tdata;
  logic        ram0_valid, ram1_ready, ram1_valid, m_tready;
  logic [7:0]  ram1_addr;
  logic        ram1_read, m_tvalid, m_tlast;
  logic        in_full, in_empty, in_overflow, out_full, out_empty, out_overflow;

  int n_vec = 0;
  int n_err = 0;

  cr_ram1_engine_fifo dut (
    .clk(clk), .reset_n(reset_n),
    .ram0_data(ram0_data), .ram0_valid(ram0_valid),
    .ram1_ready(ram1_ready), .ram1_addr(ram1_addr), .ram1_read(ram1_read),
    .ram1_data(ram1_data), .ram1_valid(ram1_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .in_full(in_full), .in_empty(in_empty), .in_overflow(in_overflow),
    .out_full(out_full), .out_empty(out_empty), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;  logic [15:0] d0; logic rdy;
    logic        v1;  logic [15:0] d1; logic trdy;
    logic        rd;  logic [7:0]  addr; logic tv; logic [15:0] td;
    logic        ie, ifl, io, oe, ofl, oo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v0, logic [15:0] d0, logic rdy,
                              logic v1, logic [15:0] d1, logic trdy,
                              logic rd, logic [7:0] addr, logic tv, logic [15:0] td,
                              logic ie, logic ifl, logic io,
                              logic oe, logic ofl, logic oo);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.rdy = rdy; v.v1 = v1; v.d1 = d1; v.trdy = trdy;
    v.rd = rd; v.addr = addr; v.tv = tv; v.td = td;
    v.ie = ie; v.ifl = ifl; v.io = io; v.oe = oe; v.ofl = ofl; v.oo = oo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ram0_valid = 0; ram0_data = '0; ram1_ready = 0;
    ram1_valid = 0; ram1_data = '0; m_tready = 0;
  endtask

  task automatic chk_flags(string tag, logic ie, logic ifl, logic io,
                           logic oe, logic ofl, logic oo);
    chk({tag, ".in_empty"},     in_empty,     ie);
    chk({tag, ".in_full"},      in_full,      ifl);
    chk({tag, ".in_overflow"},  in_overflow,  io);
    chk({tag, ".out_empty"},    out_empty,    oe);
    chk({tag, ".out_full"},     out_full,     ofl);
    chk({tag, ".out_overflow"}, out_overflow, oo);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) tick();
    chk_flags("reset", 1, 0, 0, 1, 0, 0);
    chk("reset.ram1_read", ram1_read, 0);
    chk("reset.ram1_addr", ram1_addr, 0);
    chk("reset.m_tvalid",  m_tvalid,  0);
    chk("reset.m_tlast",   m_tlast,   0);
    reset_n = 1;
  endtask

  initial begin
    // v0 d0 rdy v1 d1 trdy | rd addr tv td | ie if io oe of oo
    // Single transaction
    tbl.push_back(mk(1,16'h1234,1, 0,16'h0,0,   0,8'h00,0,16'h0,    0,0,0, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    0,16'h0,0,   1,8'h34,0,16'h0,    1,0,0, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    1,16'hBEEF,0,0,8'h34,1,16'hBEEF, 1,0,0, 0,0,0));
    tbl.push_back(mk(0,16'h0,0,    0,16'h0,1,   0,8'h34,0,16'h0,    1,0,0, 1,0,0));
    // Input overflow
    tbl.push_back(mk(1,16'h0001,0, 0,16'h0,0,   0,8'h34,0,16'h0,    0,0,0, 1,0,0));
    tbl.push_back(mk(1,16'h0002,0, 0,16'h0,0,   0,8'h34,0,16'h0,    0,0,0, 1,0,0));
    tbl.push_back(mk(1,16'h0003,0, 0,16'h0,0,   0,8'h34,0,16'h0,    0,0,0, 1,0,0));
    tbl.push_back(mk(1,16'h0004,0, 0,16'h0,0,   0,8'h34,0,16'h0,    0,1,0, 1,0,0));
    tbl.push_back(mk(1,16'h0005,0, 0,16'h0,0,   0,8'h34,0,16'h0,    0,1,1, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    0,16'h0,0,   1,8'h01,0,16'h0,    0,0,1, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    0,16'h0,0,   1,8'h02,0,16'h0,    0,0,1, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    0,16'h0,0,   1,8'h03,0,16'h0,    0,0,1, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    0,16'h0,0,   1,8'h04,0,16'h0,    1,0,1, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    0,16'h0,0,   0,8'h04,0,16'h0,    1,0,1, 1,0,0));
    // Push into empty with ready: no pop that cycle; then push+pop together
    tbl.push_back(mk(1,16'h56A7,1, 0,16'h0,0,   0,8'h04,0,16'h0,    0,0,1, 1,0,0));
    tbl.push_back(mk(1,16'h0042,1, 0,16'h0,0,   1,8'hA7,0,16'h0,    0,0,1, 1,0,0));
    tbl.push_back(mk(0,16'h0,1,    0,16'h0,0,   1,8'h42,0,16'h0,    1,0,1, 1,0,0));
    tbl.push_back(mk(0,16'h0,0,    0,16'h0,0,   0,8'h42,0,16'h0,    1,0,1, 1,0,0));

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      ram0_valid = tbl[i].v0; ram0_data = tbl[i].d0; ram1_ready = tbl[i].rdy;
      ram1_valid = tbl[i].v1; ram1_data = tbl[i].d1; m_tready   = tbl[i].trdy;
      tick();
      chk({tag, ".ram1_read"}, ram1_read, tbl[i].rd);
      chk({tag, ".ram1_addr"}, ram1_addr, tbl[i].addr);
      chk({tag, ".m_tvalid"},  m_tvalid,  tbl[i].tv);
      if (tbl[i].tv) chk({tag, ".m_tdata"}, m_tdata, tbl[i].td);
      chk_flags(tag, tbl[i].ie, tbl[i].ifl, tbl[i].io, tbl[i].oe, tbl[i].ofl, tbl[i].oo);
    end

    // Full-boundary push/pop on the output FIFO
    do_reset();
    for (int i = 0; i < 32; i++) begin
      ram1_valid = 1; ram1_data = 16'h0100 + 16'(i);
      tick();
    end
    chk("bound.out_full", out_full, 1);
    chk("bound.out_overflow", out_overflow, 0);
    ram1_data = 16'h01FF; m_tready = 1;
    tick();
    chk("bound.out_full_after", out_full, 1);
    chk("bound.out_overflow_after", out_overflow, 0);
    ram1_valid = 0;
    for (int i = 1; i < 32; i++) begin
      chk($sformatf("bound.drain%0d", i), m_tdata, 16'h0100 + 16'(i));
      tick();
    end
    chk("bound.last", m_tdata, 16'h01FF);
    chk("bound.last_valid", m_tvalid, 1);
    tick();
    chk("bound.empty", m_tvalid, 0);

    // Output overflow: 33 words with m_tready low
    m_tready = 0;
    for (int i = 0; i < 33; i++) begin
      ram1_valid = 1; ram1_data = 16'(i);
      tick();
      chk($sformatf("oovf.full%0d", i), out_full, (i >= 31) ? 1 : 0);
      chk($sformatf("oovf.ovf%0d", i), out_overflow, (i == 32) ? 1 : 0);
    end
    ram1_valid = 0; m_tready = 1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("oovf.valid%0d", i), m_tvalid, 1);
      chk($sformatf("oovf.data%0d", i), m_tdata, 16'(i));
      tick();
    end
    chk("oovf.drained", m_tvalid, 0);
    chk("oovf.sticky", out_overflow, 1);

    // Mid-stream reset with both FIFOs partially full
    do_reset();
    ram1_ready = 0; m_tready = 0;
    ram0_valid = 1; ram0_data = 16'hAAAA; ram1_valid = 1; ram1_data = 16'h5555;
    tick();
    ram0_valid = 1; ram0_data = 16'h0101; ram1_valid = 1; ram1_data = 16'h6666;
    ram1_ready = 1;
    tick();
    idle_inputs();
    chk("mid.pre_in_empty", in_empty, 0);
    chk("mid.pre_tvalid", m_tvalid, 1);
    chk("mid.pre_read", ram1_read, 1);
    #2 reset_n = 0;
    #1;
    chk_flags("mid.async", 1, 0, 0, 1, 0, 0);
    chk("mid.async.ram1_read", ram1_read, 0);
    chk("mid.async.ram1_addr", ram1_addr, 0);
    chk("mid.async.m_tvalid", m_tvalid, 0);
    tick();
    reset_n = 1;
    m_tready = 1;
    tick();
    chk("mid.post_tvalid", m_tvalid, 0);
    chk("mid.post_read", ram1_read, 0);
    ram1_valid = 1; ram1_data = 16'h7777; m_tready = 0;
    tick();
    ram1_valid = 0;
    chk("mid.fresh_valid", m_tvalid, 1);
    chk("mid.fresh_data", m_tdata, 16'h7777);
    m_tready = 1;
    tick();
    chk("mid.fresh_gone", m_tvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
